// File: rtl/gen_for_seq.sv
// Sequential add/sub accumulator: one alternating (A+B)/(A-B) step per clock, COUNT steps per operand pair.
// Define GEN_FOR_PERSIST_EN to keep the accumulator across transactions (only reset reloads INIT).
module gen_for_seq #(
  parameter int NBITS  = 8,
  parameter int COUNT  = 4,
  parameter int OFFSET = 17,
  parameter int INIT   = 1,
  localparam int CW    = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [NBITS-1:0] A,
  input  logic [NBITS-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [NBITS-1:0] XOUT,
  output logic             BUSY,
  output logic [CW-1:0]    ITER
);

  if (COUNT < 1) begin : g_bad_count
    $error("gen_for_seq: COUNT must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [NBITS-1:0] INIT_W = NBITS'(INIT);
  localparam logic [NBITS-1:0] OFF_W  = NBITS'(OFFSET);
  localparam logic [CW-1:0]    LAST   = CW'(COUNT - 1);

  state_t           state_q, state_d;
  logic [NBITS-1:0] acc_q, acc_d;
  logic [NBITS-1:0] a_q, a_d;
  logic [NBITS-1:0] b_q, b_d;
  logic [NBITS-1:0] xout_q, xout_d;
  logic [CW-1:0]    iter_q, iter_d;
  logic [NBITS-1:0] step_c;
  logic [NBITS-1:0] acc_step_c;
  logic             last_c;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (IN_VALID) state_d = S_RUN;
      S_RUN:   if (last_c) state_d = S_DONE;
      S_DONE:  if (OUT_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = (state_q == S_IDLE);
    BUSY      = (state_q != S_IDLE);
    OUT_VALID = (state_q == S_DONE);
    XOUT      = xout_q;
    ITER      = iter_q;
  end

  // Even steps add A+B, odd steps add A-B; both wrap modulo 2^NBITS.
  assign step_c     = iter_q[0] ? (a_q - b_q) : (a_q + b_q);
  assign acc_step_c = acc_q + step_c;
  assign last_c     = (iter_q == LAST);

  always_comb begin
    acc_d  = acc_q;
    a_d    = a_q;
    b_d    = b_q;
    xout_d = xout_q;
    iter_d = iter_q;
    unique case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          a_d    = A;
          b_d    = B;
          iter_d = '0;
`ifdef GEN_FOR_PERSIST_EN
          acc_d  = acc_q;
`else
          acc_d  = INIT_W;
`endif
        end
      end
      S_RUN: begin
        acc_d  = acc_step_c;
        iter_d = iter_q + CW'(1);
        if (last_c) xout_d = acc_step_c - OFF_W;
      end
      S_DONE: begin
        if (OUT_READY) iter_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q  <= INIT_W;
      a_q    <= '0;
      b_q    <= '0;
      xout_q <= '0;
      iter_q <= '0;
    end else begin
      acc_q  <= acc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      xout_q <= xout_d;
      iter_q <= iter_d;
    end
  end

endmodule

// File: tb/tb_gen_for_seq.sv
// Scoreboard bench for gen_for_seq: driver pushes model results, negedge monitor checks outputs.
module tb_gen_for_seq;

  localparam int NBITS  = 8;
  localparam int COUNT  = 4;
  localparam int OFFSET = 17;
  localparam int INIT   = 1;
  localparam int CW     = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             IN_VALID;
  logic             IN_READY;
  logic [NBITS-1:0] A;
  logic [NBITS-1:0] B;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [NBITS-1:0] XOUT;
  logic             BUSY;
  logic [CW-1:0]    ITER;

  gen_for_seq #(
    .NBITS (NBITS),
    .COUNT (COUNT),
    .OFFSET(OFFSET),
    .INIT  (INIT)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .A        (A),
    .B        (B),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .XOUT     (XOUT),
    .BUSY     (BUSY),
    .ITER     (ITER)
  );

  always #5 CLK = ~CLK;

  int               n_checks = 0;
  int               n_pass = 0;
  int               cyc = 0;
  int               accept_edge = 0;
  bit               prev_ov = 1'b0;
  int               rdy_mode = 0;
  logic [NBITS-1:0] exp_q[$];
  int               model_acc = INIT;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference: plain modular arithmetic over the COUNT alternating steps.
  function automatic logic [NBITS-1:0] model(input int a, input int b);
    int m;
    int acc;
    m = 1 << NBITS;
`ifdef GEN_FOR_PERSIST_EN
    acc = model_acc;
`else
    acc = INIT;
`endif
    for (int k = 0; k < COUNT; k++) begin
      if (k % 2 == 0) acc = (acc + a + b) % m;
      else acc = (acc + a - b + m) % m;
    end
    model_acc = acc;
    return NBITS'((acc - OFFSET + m) % m);
  endfunction

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (rdy_mode == 0) OUT_READY = 1'b1;
      else if (rdy_mode == 1) OUT_READY = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_ov = 1'b0;
    end else begin
      if (IN_VALID && IN_READY) accept_edge = cyc + 1;
      if (BUSY && !OUT_VALID) check("iter", ITER, (cyc - accept_edge) % (1 << CW));
      if (OUT_VALID && !prev_ov) check("latency", cyc - accept_edge, COUNT);
      if (OUT_VALID) begin
        if (exp_q.size() == 0) fail_now("unexpected_out");
        else if (OUT_READY) check("xout", XOUT, exp_q.pop_front());
        else check("xout_hold", XOUT, exp_q[0]);
      end
      prev_ov = OUT_VALID;
    end
  end

  task automatic send(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
    int unsigned n = 0;
    while (!IN_READY && n < 300) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (!IN_READY) begin
      fail_now("send_wait_ready");
      return;
    end
    IN_VALID = 1'b1;
    A = a;
    B = b;
    exp_q.push_back(model(a, b));
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    A = NBITS'($urandom);
    B = NBITS'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    while ((BUSY || exp_q.size() != 0) && n < 300) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (BUSY || exp_q.size() != 0) fail_now(name);
  endtask

  initial begin
    RST_N = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    A = '0;
    B = '0;
    rdy_mode = 2;
    #3;
    check("rst_in_ready", IN_READY, 1);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_xout", XOUT, 0);
    check("rst_iter", ITER, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    rdy_mode = 0;
    @(posedge CLK);
    #1;

    send(8'd5, 8'd3);
    send(8'd3, 8'd5);
    send(8'd200, 8'd100);
    wait_idle("idle_after_directed");

    // Backpressure: output must hold while producer keeps pulsing IN_VALID.
    rdy_mode = 2;
    OUT_READY = 1'b0;
    send(8'd5, 8'd3);
    begin
      int unsigned n = 0;
      while (!OUT_VALID && n < 50) begin
        @(posedge CLK);
        #1;
        n++;
      end
      if (!OUT_VALID) fail_now("bp_wait_valid");
    end
    for (int i = 0; i < 10; i++) begin
      IN_VALID = 1'(i % 2);
      A = NBITS'($urandom);
      B = NBITS'($urandom);
      @(posedge CLK);
      #1;
      check("bp_in_ready", IN_READY, 0);
      check("bp_out_valid", OUT_VALID, 1);
    end
    IN_VALID = 1'b1;
    A = 8'd5;
    B = 8'd3;
    OUT_READY = 1'b1;
    exp_q.push_back(model(5, 3));
    @(posedge CLK);
    #1;
    check("release_out_valid", OUT_VALID, 0);
    check("release_in_ready", IN_READY, 1);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    check("next_accept_busy", BUSY, 1);
    rdy_mode = 0;
    wait_idle("idle_after_bp");

    // Abort mid-RUN: no output may appear for the aborted pair.
    send(8'd5, 8'd3);
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    check("pre_abort_iter", ITER, 2);
    RST_N = 1'b0;
    #1;
    check("abort_out_valid", OUT_VALID, 0);
    check("abort_busy", BUSY, 0);
    check("abort_xout", XOUT, 0);
    check("abort_in_ready", IN_READY, 1);
    exp_q.delete();
    model_acc = INIT;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    send(8'd5, 8'd3);
    send(8'd5, 8'd3);
    wait_idle("idle_after_abort");

    rdy_mode = 1;
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge CLK);
        #1;
      end
      send(NBITS'($urandom), NBITS'($urandom));
    end
    wait_idle("idle_after_random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
